sdp_ram_burst_reader: RTL and testbench

Read-side burst sequencer placed directly downstream of the byte-write simple-dual-port RAM. It accepts a burst command (start address, length) and drives the RAM read port (ena, read_addr). It absorbs the RAM's 1-cycle registered read latency, then presents the words as a valid/ready stream with a last flag. A 2-entry output buffer with credit-based issue provides full 1-word/cycle throughput and loses no data under arbitrary backpressure.

---
 rtl/sdp_ram_burst_reader.sv | 145 ++++++++++++++
 tb/tb_sdp_ram_burst_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_burst_reader.sv
// sdp_ram_burst_reader
//   Read-side burst sequencer for a simple-dual-port RAM with a 1-cycle registered read.
//   Accepts a (start_addr, burst_len) command, issues one RAM read per cycle while buffer
//   credit allows, captures each word the cycle after its issue into a 2-entry FIFO, and
//   presents the words as a valid/ready stream with a last flag.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   start                command strobe, honoured only when idle
//   start_addr           first word address
//   burst_len            number of words (0 = empty burst, completes without RAM access)
//   busy                 high from the cycle after an accepted start through the done cycle
//   done                 one-cycle completion pulse
//   ram_ena              RAM read strobe (combinational from state and m_ready)
//   ram_read_addr        RAM read address
//   ram_dout             RAM registered read data
//   m_data/m_valid       stream output, driven from the FIFO head register
//   m_ready              stream backpressure
//   m_last               final beat of the burst, qualified by m_valid
module sdp_ram_burst_reader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_ena,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e                  state_q;
   logic                    busy_q;
   logic                    done_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LEN_WIDTH-1:0]    issue_rem_q;
   logic [LEN_WIDTH-1:0]    beat_rem_q;
   logic                    inflight_q;
   logic [1:0]              occ_q;
   logic                    rd_ptr_q;
   logic                    wr_ptr_q;
   logic [DATA_WIDTH-1:0]   buf_q [2];

   logic                    pop;
   logic [2:0]              load;

   always_comb begin
      m_valid = (occ_q != 2'd0);
      m_data  = buf_q[rd_ptr_q];
      m_last  = m_valid && (beat_rem_q == LEN_WIDTH'(1));
      pop     = m_valid && m_ready;
      // Slots that will be committed after this cycle if no new read is issued; the read
      // in flight already owns a slot, so a new issue is only safe while this is below 2.
      load    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
      ram_ena = (state_q == StRun) && (issue_rem_q != '0) && (load < 3'd2);
   end

   assign ram_read_addr = addr_q;
   assign busy          = busy_q;
   assign done          = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         addr_q      <= '0;
         issue_rem_q <= '0;
         beat_rem_q  <= '0;
         inflight_q  <= 1'b0;
         occ_q       <= 2'd0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         buf_q[0]    <= '0;
         buf_q[1]    <= '0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= ram_ena;

         if (ram_ena) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);  // wraps modulo the RAM depth
            issue_rem_q <= issue_rem_q - LEN_WIDTH'(1);
         end

         // ram_dout is only meaningful the cycle after our own issue; the writer may drive
         // the shared RAM enable at any other time.
         if (inflight_q) begin
            buf_q[wr_ptr_q] <= ram_dout;
            wr_ptr_q        <= ~wr_ptr_q;
         end

         if (pop) begin
            rd_ptr_q   <= ~rd_ptr_q;
            beat_rem_q <= beat_rem_q - LEN_WIDTH'(1);
         end

         occ_q <= occ_q + 2'(inflight_q) - 2'(pop);

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (burst_len != '0) begin
                     state_q     <= StRun;
                     addr_q      <= start_addr;
                     issue_rem_q <= burst_len;
                     beat_rem_q  <= burst_len;
                  end else begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end
               end
            end
            StRun: begin
               if (ram_ena && (issue_rem_q == LEN_WIDTH'(1))) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (pop && m_last) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sdp_ram_burst_reader.sv
// tb_sdp_ram_burst_reader
//   Bench for sdp_ram_burst_reader: a behavioural read-first RAM, a stream consumer with
//   selectable backpressure, and a beat-queue reference model checked every cycle.
module tb_sdp_ram_burst_reader;
   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int LW    = 11;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [LW-1:0] burst_len = '0;
   logic          busy, done, ram_ena, m_valid, m_last;
   logic          m_ready = 1'b0;
   logic [AW-1:0] ram_read_addr;
   logic [DW-1:0] ram_dout = '0;
   logic [DW-1:0] m_data;

   sdp_ram_burst_reader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .start_addr    (start_addr),
      .burst_len     (burst_len),
      .busy          (busy),
      .done          (done),
      .ram_ena       (ram_ena),
      .ram_read_addr (ram_read_addr),
      .ram_dout      (ram_dout),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_last        (m_last)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM: registered read; when not enabled by us, the output wanders (writer activity).
   logic [DW-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (ram_ena) ram_dout <= ram_mem[ram_read_addr];
      else         ram_dout <= $urandom();
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   bit            exp_busy = 0, exp_done = 0, nb, nd, pop_now;
   logic [DW-1:0] exp_q [$];
   int            iss_total = 0, iss_done = 0, pops = 0;
   logic [AW-1:0] base_addr = '0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data = '0;
   // per-burst observation logs, cleared on each accepted start
   int            acc_cyc = 0, first_valid_cyc = 0, done_cyc = 0;
   int            ena_cnt = 0, ena_first = 0, ena_last = 0, last_cnt = 0;
   bit            saw_valid = 0;
   logic [DW-1:0] beat_log [$];
   logic [AW-1:0] addr_log [$];

   always @(negedge clk) begin
      if (rst) begin
         exp_busy = 0; exp_done = 0; exp_q.delete();
         iss_total = 0; iss_done = 0; pops = 0; prev_stall = 0;
      end else begin
         pop_now = m_valid && m_ready;
         chk("busy", busy, exp_busy);
         chk("done", done, exp_done);
         if (ram_ena) begin
            chk("ena_allowed", iss_done < iss_total, 1);
            chk("read_addr", ram_read_addr, AW'(base_addr + iss_done));
            chk("issue_ahead_le2", (iss_done + 1 - pops - pop_now) <= 2, 1);
            ena_cnt++;
            if (ena_cnt == 1) ena_first = cyc;
            ena_last = cyc;
            addr_log.push_back(ram_read_addr);
         end
         if (prev_stall) begin
            chk("valid_hold", m_valid, 1);
            chk("data_hold", m_data, prev_data);
         end
         if (m_valid) begin
            if (exp_q.size() == 0) chk("spurious_valid", m_valid, 0);
            else begin
               chk("data", m_data, exp_q[0]);
               chk("last", m_last, exp_q.size() == 1);
            end
            if (!saw_valid) begin saw_valid = 1; first_valid_cyc = cyc; end
         end else begin
            chk("last_unqualified", m_last, 0);
         end
         if (pop_now) begin
            beat_log.push_back(m_data);
            if (m_last) last_cnt++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         if (done) done_cyc = cyc;

         // advance the model one cycle
         nb = exp_busy;
         nd = 0;
         if (exp_done) nb = 0;
         if (!exp_busy && start) begin
            acc_cyc = cyc; nb = 1;
            iss_total = burst_len; iss_done = 0; pops = 0; base_addr = start_addr;
            ena_cnt = 0; last_cnt = 0; saw_valid = 0;
            beat_log.delete(); addr_log.delete();
            if (burst_len == 0) nd = 1;
            else for (int i = 0; i < burst_len; i++) exp_q.push_back(ram_mem[AW'(start_addr + i)]);
         end
         if (ram_ena) iss_done++;
         if (pop_now && exp_q.size() > 0) begin
            if (exp_q.size() == 1) nd = 1;
            void'(exp_q.pop_front());
            pops++;
         end
         exp_busy = nb;
         exp_done = nd;
      end
   end

   // ---------------- consumer ----------------
   int ready_mode = 0;  // 0 always, 1 pattern, 2 random, 3 never
   int ready_pct  = 50;
   int rpos       = 0;
   bit pat [6]    = '{1, 0, 0, 1, 0, 1};
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       begin m_ready = pat[rpos % 6]; rpos++; end
         2:       m_ready = ($urandom_range(0, 99) < ready_pct);
         default: m_ready = 1'b0;
      endcase
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int addr, input int len);
      start = 1'b1; start_addr = AW'(addr); burst_len = LW'(len);
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin step(); k++; end
      chk("done_within_budget", done, 1);
      step();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ram_ena"}, ram_ena, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_read_addr"}, ram_read_addr, 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = i * 32'h01010101;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      // basic burst, no backpressure
      ready_mode = 0;
      launch(5, 4);
      wait_done(100);
      chk("t1_first_ena_lat", ena_first - acc_cyc, 1);
      chk("t1_first_valid_lat", first_valid_cyc - acc_cyc, 3);
      chk("t1_done_lat", done_cyc - acc_cyc, 7);
      chk("t1_beats", beat_log.size(), 4);
      chk("t1_last_cnt", last_cnt, 1);
      for (int i = 0; i < 4; i++)
         if (i < beat_log.size()) chk("t1_word", beat_log[i], 32'h05050505 + i * 32'h01010101);

      // address wrap
      launch(1022, 4);
      wait_done(100);
      chk("wrap_issues", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         chk("wrap_a0", addr_log[0], 1022);
         chk("wrap_a1", addr_log[1], 1023);
         chk("wrap_a2", addr_log[2], 0);
         chk("wrap_a3", addr_log[3], 1);
      end
      chk("wrap_beats", beat_log.size(), 4);
      if (beat_log.size() == 4) begin
         chk("wrap_d0", beat_log[0], 32'(1022 * 32'h01010101));
         chk("wrap_d1", beat_log[1], 32'(1023 * 32'h01010101));
         chk("wrap_d2", beat_log[2], 32'h00000000);
         chk("wrap_d3", beat_log[3], 32'h01010101);
      end

      // patterned backpressure
      ready_mode = 1; rpos = 0;
      launch(100, 8);
      wait_done(200);
      chk("bp_beats", beat_log.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < beat_log.size()) chk("bp_word", beat_log[i], (100 + i) * 32'h01010101);

      // empty burst, with a second start held into the done cycle
      ready_mode = 0;
      start = 1'b1; start_addr = AW'(7); burst_len = '0;
      step();
      burst_len = LW'(5);
      step();
      start = 1'b0;
      repeat (4) step();
      chk("empty_done_lat", done_cyc - acc_cyc, 1);
      chk("empty_no_ena", ena_cnt, 0);
      chk("empty_no_beats", beat_log.size(), 0);
      chk("empty_second_ignored", busy, 0);

      // full-depth burst
      launch(300, 1024);
      wait_done(3000);
      chk("full_ena_cnt", ena_cnt, 1024);
      chk("full_ena_span", ena_last - ena_first, 1023);
      chk("full_beats", beat_log.size(), 1024);
      chk("full_last_cnt", last_cnt, 1);
      chk("full_done_lat", done_cyc - acc_cyc, 1027);

      // randomized bursts, back-to-back, random backpressure and RAM contents
      for (int b = 0; b < 30; b++) begin
         for (int j = 0; j < 16; j++) ram_mem[$urandom_range(0, DEPTH - 1)] = $urandom();
         ready_mode = (b % 5 == 0) ? 0 : 2;
         ready_pct  = $urandom_range(20, 100);
         launch($urandom_range(0, DEPTH - 1), $urandom_range(0, 24));
         wait_done(2000);
      end

      // reset mid-burst: one word buffered, one read in flight
      ready_mode = 3;
      launch(40, 8);
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      repeat (2) step();
      rst = 1'b0;
      ready_mode = 0;
      repeat (4) step();
      chk("post_rst_idle_valid", m_valid, 0);
      launch(0, 2);
      wait_done(100);
      chk("post_rst_beats", beat_log.size(), 2);
      if (beat_log.size() == 2) begin
         chk("post_rst_d0", beat_log[0], ram_mem[0]);
         chk("post_rst_d1", beat_log[1], ram_mem[1]);
      end
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d cycles, expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
